// File: rtl/swerv_exu_pkg.sv
// Shared types for the dual-lane execute unit: decode/predict packets and encodings.
// No logic, no latency; no flow control.
// Packet layouts are fixed by the decode stage that produces them.
package swerv_types;

    typedef struct packed {
        logic       valid;
        logic       imm;
        logic [3:0] op;
        logic       unsign;
        logic [2:0] br;
        logic       jal;
    } alu_pkt_t;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic        pc4;
        logic [31:1] prett;
    } predict_pkt_t;

    // Control subset that travels into E1; the imm select is consumed in D.
    typedef struct packed {
        logic [3:0] op;
        logic       unsign;
        logic [2:0] br;
        logic       jal;
    } e1_ctl_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;

    function automatic logic [31:1] pc_next(input logic [31:1] pc, input logic pc4);
        return pc + (pc4 ? 31'd2 : 31'd1);
    endfunction

    function automatic e1_ctl_t to_e1_ctl(input alu_pkt_t ap);
        e1_ctl_t c;
        c.op     = ap.op;
        c.unsign = ap.unsign;
        c.br     = ap.br;
        c.jal    = ap.jal;
        return c;
    endfunction

endpackage

// File: rtl/swerv_exu_alu_ctl.sv
// ALU, branch compare, target generation and mispredict detection for one lane.
// Purely combinational (0 cycles) from the E1 registers.
// No flow control; the enclosing pipeline holds inputs during a freeze.
module exu_alu_ctl
    import swerv_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic              vld,
    input  e1_ctl_t           ctl,
    input  predict_pkt_t      pp,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic [31:1]       pc,
    input  logic [12:1]       br_immed,
    output logic [XLEN-1:0]   result,
    output logic              mispredict,
    output logic [31:1]       path
);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [4:0]      shamt;
    logic            lt_s;
    logic            lt_u;
    logic            lt;
    logic            eq;
    logic            cond;
    logic            taken;
    logic            is_cti;
    logic            pred_taken;
    logic [31:1]     fall_thru;
    logic [31:1]     target;

    assign sum        = a + b;
    assign diff       = a - b;
    assign shamt      = b[4:0];
    assign lt_s       = $signed(a) < $signed(b);
    assign lt_u       = a < b;
    assign lt         = ctl.unsign ? lt_u : lt_s;
    assign eq         = (a == b);
    assign fall_thru  = pc_next(pc, pp.pc4);
    assign pred_taken = pp.valid & pp.taken;

    always_comb begin
        result = '0;
        unique case (ctl.op)
            OP_ADD:  result = sum;
            OP_SUB:  result = diff;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = XLEN'($signed(a) >>> shamt);
            OP_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            default: result = '0;
        endcase
        // A jump writes its link address instead of the ALU value.
        if (ctl.jal) begin
            result = XLEN'({fall_thru, 1'b0});
        end
    end

    always_comb begin
        cond = 1'b0;
        unique case (ctl.br)
            BR_BEQ:  cond = eq;
            BR_BNE:  cond = ~eq;
            BR_BLT:  cond = lt;
            BR_BGE:  cond = ~lt;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        is_cti     = ctl.jal | (ctl.br != BR_NONE);
        taken      = ctl.jal | cond;
        target     = ctl.jal ? sum[31:1] : (pc + {{19{br_immed[12]}}, br_immed});
        mispredict = vld & is_cti &
                     ((taken != pred_taken) | (taken & (target != pp.prett)));
        path       = taken ? target : fall_thru;
    end

endmodule

// File: rtl/swerv_exu.sv
// Dual-lane integer execute: D-stage operand muxes, E1 ALU/branch, E2-E4 result staging.
// D->E1 one cycle, E1->E4 three cycles; flush and E1 results are combinational from E1.
// lsu_freeze_dc3 holds every register; flushes squash the instruction entering E1.
module swerv_exu
    import swerv_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_freeze_dc3,
    input  logic              dec_i0_alu_decode_d,
    input  logic              dec_i1_alu_decode_d,
    input  alu_pkt_t          i0_ap,
    input  alu_pkt_t          i1_ap,
    input  logic [XLEN-1:0]   gpr_i0_rs1_d,
    input  logic [XLEN-1:0]   gpr_i0_rs2_d,
    input  logic [XLEN-1:0]   gpr_i1_rs1_d,
    input  logic [XLEN-1:0]   gpr_i1_rs2_d,
    input  logic [XLEN-1:0]   dec_i0_immed_d,
    input  logic [XLEN-1:0]   dec_i1_immed_d,
    input  logic              dec_i0_rs1_bypass_en_d,
    input  logic              dec_i0_rs2_bypass_en_d,
    input  logic              dec_i1_rs1_bypass_en_d,
    input  logic              dec_i1_rs2_bypass_en_d,
    input  logic [XLEN-1:0]   i0_rs1_bypass_data_d,
    input  logic [XLEN-1:0]   i0_rs2_bypass_data_d,
    input  logic [XLEN-1:0]   i1_rs1_bypass_data_d,
    input  logic [XLEN-1:0]   i1_rs2_bypass_data_d,
    input  logic              dec_i0_select_pc_d,
    input  logic              dec_i1_select_pc_d,
    input  logic [31:1]       dec_i0_pc_d,
    input  logic [31:1]       dec_i1_pc_d,
    input  logic [12:1]       dec_i0_br_immed_d,
    input  logic [12:1]       dec_i1_br_immed_d,
    input  predict_pkt_t      i0_predict_p_d,
    input  predict_pkt_t      i1_predict_p_d,
    input  logic              dec_tlu_flush_lower_wb,
    input  logic [31:1]       dec_tlu_flush_path_wb,
    output logic [XLEN-1:0]   exu_lsu_rs1_d,
    output logic [XLEN-1:0]   exu_lsu_rs2_d,
    output logic [XLEN-1:0]   exu_i0_result_e1,
    output logic [XLEN-1:0]   exu_i1_result_e1,
    output logic [31:1]       exu_i0_pc_e1,
    output logic [31:1]       exu_i1_pc_e1,
    output logic              exu_i0_flush_final,
    output logic              exu_i1_flush_final,
    output logic              exu_flush_final,
    output logic [31:1]       exu_flush_path_final,
    output logic [XLEN-1:0]   exu_i0_result_e4,
    output logic [XLEN-1:0]   exu_i1_result_e4
);

    logic              lane_vld [2];
    alu_pkt_t          ap_d     [2];
    predict_pkt_t      pp_d     [2];
    logic [31:1]       pc_d     [2];
    logic [12:1]       brimm_d  [2];
    logic [XLEN-1:0]   a_d      [2];
    logic [XLEN-1:0]   b_d      [2];

    logic              vld_e1_d [2], vld_e1_q [2];
    e1_ctl_t           ctl_e1_d [2], ctl_e1_q [2];
    predict_pkt_t      pp_e1_d  [2], pp_e1_q  [2];
    logic [31:1]       pc_e1_d  [2], pc_e1_q  [2];
    logic [12:1]       brimm_e1_d [2], brimm_e1_q [2];
    logic [XLEN-1:0]   a_e1_d   [2], a_e1_q   [2];
    logic [XLEN-1:0]   b_e1_d   [2], b_e1_q   [2];
    logic [XLEN-1:0]   res_e2_d [2], res_e2_q [2];
    logic [XLEN-1:0]   res_e3_d [2], res_e3_q [2];
    logic [XLEN-1:0]   res_e4_d [2], res_e4_q [2];

    logic [XLEN-1:0]   res_e1   [2];
    logic              mp       [2];
    logic [31:1]       mp_path  [2];

    assign ap_d[0]    = i0_ap;
    assign ap_d[1]    = i1_ap;
    assign pp_d[0]    = i0_predict_p_d;
    assign pp_d[1]    = i1_predict_p_d;
    assign pc_d[0]    = dec_i0_pc_d;
    assign pc_d[1]    = dec_i1_pc_d;
    assign brimm_d[0] = dec_i0_br_immed_d;
    assign brimm_d[1] = dec_i1_br_immed_d;
    assign lane_vld[0] = dec_i0_alu_decode_d & i0_ap.valid;
    assign lane_vld[1] = dec_i1_alu_decode_d & i1_ap.valid;

    always_comb begin
        a_d[0] = dec_i0_rs1_bypass_en_d ? i0_rs1_bypass_data_d :
                 dec_i0_select_pc_d     ? XLEN'({dec_i0_pc_d, 1'b0}) : gpr_i0_rs1_d;
        b_d[0] = dec_i0_rs2_bypass_en_d ? i0_rs2_bypass_data_d :
                 i0_ap.imm              ? dec_i0_immed_d : gpr_i0_rs2_d;
        a_d[1] = dec_i1_rs1_bypass_en_d ? i1_rs1_bypass_data_d :
                 dec_i1_select_pc_d     ? XLEN'({dec_i1_pc_d, 1'b0}) : gpr_i1_rs1_d;
        b_d[1] = dec_i1_rs2_bypass_en_d ? i1_rs2_bypass_data_d :
                 i1_ap.imm              ? dec_i1_immed_d : gpr_i1_rs2_d;
    end

    assign exu_lsu_rs1_d = a_d[0];
    assign exu_lsu_rs2_d = b_d[0];

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            vld_e1_d[n]   = vld_e1_q[n];
            ctl_e1_d[n]   = ctl_e1_q[n];
            pp_e1_d[n]    = pp_e1_q[n];
            pc_e1_d[n]    = pc_e1_q[n];
            brimm_e1_d[n] = brimm_e1_q[n];
            a_e1_d[n]     = a_e1_q[n];
            b_e1_d[n]     = b_e1_q[n];
            res_e2_d[n]   = res_e2_q[n];
            res_e3_d[n]   = res_e3_q[n];
            res_e4_d[n]   = res_e4_q[n];
            if (!lsu_freeze_dc3) begin
                // The instruction entering E1 is younger than anything flushing now.
                vld_e1_d[n] = lane_vld[n] & ~exu_flush_final;
                if (lane_vld[n]) begin
                    ctl_e1_d[n]   = to_e1_ctl(ap_d[n]);
                    pp_e1_d[n]    = pp_d[n];
                    pc_e1_d[n]    = pc_d[n];
                    brimm_e1_d[n] = brimm_d[n];
                    a_e1_d[n]     = a_d[n];
                    b_e1_d[n]     = b_d[n];
                end
                res_e2_d[n] = res_e1[n];
                res_e3_d[n] = res_e2_q[n];
                res_e4_d[n] = res_e3_q[n];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                vld_e1_q[n]   <= 1'b0;
                ctl_e1_q[n]   <= '0;
                pp_e1_q[n]    <= '0;
                pc_e1_q[n]    <= '0;
                brimm_e1_q[n] <= '0;
                a_e1_q[n]     <= '0;
                b_e1_q[n]     <= '0;
                res_e2_q[n]   <= '0;
                res_e3_q[n]   <= '0;
                res_e4_q[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                vld_e1_q[n]   <= vld_e1_d[n];
                ctl_e1_q[n]   <= ctl_e1_d[n];
                pp_e1_q[n]    <= pp_e1_d[n];
                pc_e1_q[n]    <= pc_e1_d[n];
                brimm_e1_q[n] <= brimm_e1_d[n];
                a_e1_q[n]     <= a_e1_d[n];
                b_e1_q[n]     <= b_e1_d[n];
                res_e2_q[n]   <= res_e2_d[n];
                res_e3_q[n]   <= res_e3_d[n];
                res_e4_q[n]   <= res_e4_d[n];
            end
        end
    end

    exu_alu_ctl #(.XLEN(XLEN)) u_i0_alu (
        .vld        (vld_e1_q[0]),
        .ctl        (ctl_e1_q[0]),
        .pp         (pp_e1_q[0]),
        .a          (a_e1_q[0]),
        .b          (b_e1_q[0]),
        .pc         (pc_e1_q[0]),
        .br_immed   (brimm_e1_q[0]),
        .result     (res_e1[0]),
        .mispredict (mp[0]),
        .path       (mp_path[0])
    );

    exu_alu_ctl #(.XLEN(XLEN)) u_i1_alu (
        .vld        (vld_e1_q[1]),
        .ctl        (ctl_e1_q[1]),
        .pp         (pp_e1_q[1]),
        .a          (a_e1_q[1]),
        .b          (b_e1_q[1]),
        .pc         (pc_e1_q[1]),
        .br_immed   (brimm_e1_q[1]),
        .result     (res_e1[1]),
        .mispredict (mp[1]),
        .path       (mp_path[1])
    );

    // TLU flush outranks both lanes; the older lane outranks the younger.
    assign exu_i0_flush_final = ~dec_tlu_flush_lower_wb & mp[0];
    assign exu_i1_flush_final = ~dec_tlu_flush_lower_wb & ~mp[0] & mp[1];
    assign exu_flush_final    = dec_tlu_flush_lower_wb | mp[0] | mp[1];

    always_comb begin
        exu_flush_path_final = '0;
        if (dec_tlu_flush_lower_wb) begin
            exu_flush_path_final = dec_tlu_flush_path_wb;
        end else if (mp[0]) begin
            exu_flush_path_final = mp_path[0];
        end else if (mp[1]) begin
            exu_flush_path_final = mp_path[1];
        end
    end

    assign exu_i0_result_e1 = res_e1[0];
    assign exu_i1_result_e1 = res_e1[1];
    assign exu_i0_pc_e1     = pc_e1_q[0];
    assign exu_i1_pc_e1     = pc_e1_q[1];
    assign exu_i0_result_e4 = res_e4_q[0];
    assign exu_i1_result_e4 = res_e4_q[1];

endmodule

// File: tb/tb_swerv_exu.sv
// Directed self-checking bench for swerv_exu: operand muxes, ALU ops, branch/flush priority,
// result staging and freeze. Inputs driven on the falling edge, outputs sampled 1ns after rising.
module tb_swerv_exu;
    import swerv_types::*;

    logic              clk;
    logic              rst;
    logic              lsu_freeze_dc3;
    logic              dec_i0_alu_decode_d, dec_i1_alu_decode_d;
    alu_pkt_t          i0_ap, i1_ap;
    logic [31:0]       gpr_i0_rs1_d, gpr_i0_rs2_d, gpr_i1_rs1_d, gpr_i1_rs2_d;
    logic [31:0]       dec_i0_immed_d, dec_i1_immed_d;
    logic              dec_i0_rs1_bypass_en_d, dec_i0_rs2_bypass_en_d;
    logic              dec_i1_rs1_bypass_en_d, dec_i1_rs2_bypass_en_d;
    logic [31:0]       i0_rs1_bypass_data_d, i0_rs2_bypass_data_d;
    logic [31:0]       i1_rs1_bypass_data_d, i1_rs2_bypass_data_d;
    logic              dec_i0_select_pc_d, dec_i1_select_pc_d;
    logic [31:1]       dec_i0_pc_d, dec_i1_pc_d;
    logic [12:1]       dec_i0_br_immed_d, dec_i1_br_immed_d;
    predict_pkt_t      i0_predict_p_d, i1_predict_p_d;
    logic              dec_tlu_flush_lower_wb;
    logic [31:1]       dec_tlu_flush_path_wb;
    logic [31:0]       exu_lsu_rs1_d, exu_lsu_rs2_d;
    logic [31:0]       exu_i0_result_e1, exu_i1_result_e1;
    logic [31:1]       exu_i0_pc_e1, exu_i1_pc_e1;
    logic              exu_i0_flush_final, exu_i1_flush_final, exu_flush_final;
    logic [31:1]       exu_flush_path_final;
    logic [31:0]       exu_i0_result_e4, exu_i1_result_e4;

    int total = 0;
    int bad   = 0;

    swerv_exu #(.XLEN(32)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .lsu_freeze_dc3         (lsu_freeze_dc3),
        .dec_i0_alu_decode_d    (dec_i0_alu_decode_d),
        .dec_i1_alu_decode_d    (dec_i1_alu_decode_d),
        .i0_ap                  (i0_ap),
        .i1_ap                  (i1_ap),
        .gpr_i0_rs1_d           (gpr_i0_rs1_d),
        .gpr_i0_rs2_d           (gpr_i0_rs2_d),
        .gpr_i1_rs1_d           (gpr_i1_rs1_d),
        .gpr_i1_rs2_d           (gpr_i1_rs2_d),
        .dec_i0_immed_d         (dec_i0_immed_d),
        .dec_i1_immed_d         (dec_i1_immed_d),
        .dec_i0_rs1_bypass_en_d (dec_i0_rs1_bypass_en_d),
        .dec_i0_rs2_bypass_en_d (dec_i0_rs2_bypass_en_d),
        .dec_i1_rs1_bypass_en_d (dec_i1_rs1_bypass_en_d),
        .dec_i1_rs2_bypass_en_d (dec_i1_rs2_bypass_en_d),
        .i0_rs1_bypass_data_d   (i0_rs1_bypass_data_d),
        .i0_rs2_bypass_data_d   (i0_rs2_bypass_data_d),
        .i1_rs1_bypass_data_d   (i1_rs1_bypass_data_d),
        .i1_rs2_bypass_data_d   (i1_rs2_bypass_data_d),
        .dec_i0_select_pc_d     (dec_i0_select_pc_d),
        .dec_i1_select_pc_d     (dec_i1_select_pc_d),
        .dec_i0_pc_d            (dec_i0_pc_d),
        .dec_i1_pc_d            (dec_i1_pc_d),
        .dec_i0_br_immed_d      (dec_i0_br_immed_d),
        .dec_i1_br_immed_d      (dec_i1_br_immed_d),
        .i0_predict_p_d         (i0_predict_p_d),
        .i1_predict_p_d         (i1_predict_p_d),
        .dec_tlu_flush_lower_wb (dec_tlu_flush_lower_wb),
        .dec_tlu_flush_path_wb  (dec_tlu_flush_path_wb),
        .exu_lsu_rs1_d          (exu_lsu_rs1_d),
        .exu_lsu_rs2_d          (exu_lsu_rs2_d),
        .exu_i0_result_e1       (exu_i0_result_e1),
        .exu_i1_result_e1       (exu_i1_result_e1),
        .exu_i0_pc_e1           (exu_i0_pc_e1),
        .exu_i1_pc_e1           (exu_i1_pc_e1),
        .exu_i0_flush_final     (exu_i0_flush_final),
        .exu_i1_flush_final     (exu_i1_flush_final),
        .exu_flush_final        (exu_flush_final),
        .exu_flush_path_final   (exu_flush_path_final),
        .exu_i0_result_e4       (exu_i0_result_e4),
        .exu_i1_result_e4       (exu_i1_result_e4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic alu_pkt_t mk_ap(input logic [3:0] op, input logic imm,
                                       input logic [2:0] br, input logic uns, input logic jal);
        alu_pkt_t p;
        p.valid = 1'b1; p.imm = imm; p.op = op; p.unsign = uns; p.br = br; p.jal = jal;
        return p;
    endfunction

    function automatic predict_pkt_t mk_pp(input logic taken, input logic pc4, input logic [31:1] prett);
        predict_pkt_t p;
        p.valid = 1'b1; p.taken = taken; p.pc4 = pc4; p.prett = prett;
        return p;
    endfunction

    task automatic idle();
        lsu_freeze_dc3 = 0;
        dec_i0_alu_decode_d = 0; dec_i1_alu_decode_d = 0;
        i0_ap = '0; i1_ap = '0;
        gpr_i0_rs1_d = 0; gpr_i0_rs2_d = 0; gpr_i1_rs1_d = 0; gpr_i1_rs2_d = 0;
        dec_i0_immed_d = 0; dec_i1_immed_d = 0;
        dec_i0_rs1_bypass_en_d = 0; dec_i0_rs2_bypass_en_d = 0;
        dec_i1_rs1_bypass_en_d = 0; dec_i1_rs2_bypass_en_d = 0;
        i0_rs1_bypass_data_d = 0; i0_rs2_bypass_data_d = 0;
        i1_rs1_bypass_data_d = 0; i1_rs2_bypass_data_d = 0;
        dec_i0_select_pc_d = 0; dec_i1_select_pc_d = 0;
        dec_i0_pc_d = '0; dec_i1_pc_d = '0;
        dec_i0_br_immed_d = '0; dec_i1_br_immed_d = '0;
        i0_predict_p_d = '0; i1_predict_p_d = '0;
        dec_tlu_flush_lower_wb = 0; dec_tlu_flush_path_wb = '0;
    endtask

    // Idle one full cycle so E1 holds no valid instruction.
    task automatic drain();
        @(negedge clk); idle();
        @(posedge clk); #1;
    endtask

    task automatic drive_br(input int lane, input alu_pkt_t ap, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [31:1] pc,
                            input logic [12:1] off, input predict_pkt_t pp);
        if (lane == 0) begin
            dec_i0_alu_decode_d = 1; i0_ap = ap; gpr_i0_rs1_d = rs1; gpr_i0_rs2_d = rs2;
            dec_i0_pc_d = pc; dec_i0_br_immed_d = off; i0_predict_p_d = pp;
        end else begin
            dec_i1_alu_decode_d = 1; i1_ap = ap; gpr_i1_rs1_d = rs1; gpr_i1_rs2_d = rs2;
            dec_i1_pc_d = pc; dec_i1_br_immed_d = off; i1_predict_p_d = pp;
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        repeat (4) @(posedge clk);
        #1;
        if (exu_i0_result_e1 !== 32'h0) begin $display("FAIL rst_i0_e1 got=%h exp=0", exu_i0_result_e1); bad++; end
        total++;
        if (exu_i1_result_e1 !== 32'h0) begin $display("FAIL rst_i1_e1 got=%h exp=0", exu_i1_result_e1); bad++; end
        total++;
        if (exu_i0_pc_e1 !== 31'h0) begin $display("FAIL rst_i0_pc got=%h exp=0", exu_i0_pc_e1); bad++; end
        total++;
        if (exu_i0_result_e4 !== 32'h0 || exu_i1_result_e4 !== 32'h0) begin
            $display("FAIL rst_e4 got=%h/%h exp=0", exu_i0_result_e4, exu_i1_result_e4); bad++;
        end
        total++;
        if ({exu_flush_final, exu_i0_flush_final, exu_i1_flush_final} !== 3'b000) begin
            $display("FAIL rst_flush got=%b%b%b exp=000", exu_flush_final, exu_i0_flush_final, exu_i1_flush_final); bad++;
        end
        total++;
        if (exu_flush_path_final !== 31'h0) begin $display("FAIL rst_path got=%h exp=0", exu_flush_path_final); bad++; end
        total++;
        @(negedge clk); rst = 0;
    endtask

    task automatic test_add_pipeline();
        @(negedge clk);
        dec_i0_alu_decode_d = 1; i0_ap = mk_ap(OP_ADD, 1, BR_NONE, 0, 0);
        gpr_i0_rs1_d = 5; dec_i0_immed_d = 7; dec_i0_pc_d = 31'h123;
        dec_i1_alu_decode_d = 1; i1_ap = mk_ap(OP_SUB, 0, BR_NONE, 0, 0);
        gpr_i1_rs1_d = 20; gpr_i1_rs2_d = 30;
        #1;
        if (exu_lsu_rs1_d !== 32'd5 || exu_lsu_rs2_d !== 32'd7) begin
            $display("FAIL lsu_rs_d got=%h/%h exp=5/7", exu_lsu_rs1_d, exu_lsu_rs2_d); bad++;
        end
        total++;
        @(posedge clk); #1;
        if (exu_i0_result_e1 !== 32'd12) begin $display("FAIL add_e1 got=%h exp=c", exu_i0_result_e1); bad++; end
        total++;
        if (exu_i1_result_e1 !== 32'hFFFF_FFF6) begin $display("FAIL sub_e1 got=%h exp=fffffff6", exu_i1_result_e1); bad++; end
        total++;
        if (exu_i0_pc_e1 !== 31'h123) begin $display("FAIL pc_e1 got=%h exp=123", exu_i0_pc_e1); bad++; end
        total++;
        @(negedge clk); idle();
        repeat (2) @(posedge clk);
        #1;
        if (exu_i0_result_e4 !== 32'd0) begin $display("FAIL add_e4_early got=%h exp=0", exu_i0_result_e4); bad++; end
        total++;
        @(posedge clk); #1;
        if (exu_i0_result_e4 !== 32'd12) begin $display("FAIL add_e4 got=%h exp=c", exu_i0_result_e4); bad++; end
        total++;
        if (exu_i1_result_e4 !== 32'hFFFF_FFF6) begin $display("FAIL sub_e4 got=%h exp=fffffff6", exu_i1_result_e4); bad++; end
        total++;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic test_back_to_back();
        vec_t v[10];
        v[0] = '{OP_AND,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0};
        v[1] = '{OP_OR,   32'h0000_F000, 32'h0000_000F, 32'h0000_F00F};
        v[2] = '{OP_XOR,  32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0};
        v[3] = '{OP_SLL,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010};
        v[4] = '{OP_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
        v[5] = '{OP_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        v[6] = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        v[7] = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        v[8] = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
        v[9] = '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dec_i0_alu_decode_d = 1; i0_ap = mk_ap(v[i].op, 0, BR_NONE, 0, 0);
            gpr_i0_rs1_d = v[i].a; gpr_i0_rs2_d = v[i].b;
            @(posedge clk); #1;
            if (exu_i0_result_e1 !== v[i].exp) begin
                $display("FAIL alu_op%0d got=%h exp=%h", i, exu_i0_result_e1, v[i].exp); bad++;
            end
            total++;
            if (i >= 3) begin
                if (exu_i0_result_e4 !== v[i-3].exp) begin
                    $display("FAIL b2b_e4_%0d got=%h exp=%h", i, exu_i0_result_e4, v[i-3].exp); bad++;
                end
                total++;
            end
        end
        drain();
    endtask

    task automatic test_bypass();
        @(negedge clk);
        dec_i0_alu_decode_d = 1; i0_ap = mk_ap(OP_ADD, 1, BR_NONE, 0, 0);
        dec_i0_rs1_bypass_en_d = 1; i0_rs1_bypass_data_d = 32'h100;
        dec_i0_select_pc_d = 1; dec_i0_pc_d = 31'h40; gpr_i0_rs1_d = 3; dec_i0_immed_d = 0;
        #1;
        if (exu_lsu_rs1_d !== 32'h100) begin $display("FAIL byp_a got=%h exp=100", exu_lsu_rs1_d); bad++; end
        total++;
        @(posedge clk); #1;
        if (exu_i0_result_e1 !== 32'h100) begin $display("FAIL byp_add got=%h exp=100", exu_i0_result_e1); bad++; end
        total++;
        @(negedge clk);
        dec_i0_rs1_bypass_en_d = 0;
        dec_i0_rs2_bypass_en_d = 1; i0_rs2_bypass_data_d = 32'h55; dec_i0_immed_d = 7;
        #1;
        if (exu_lsu_rs1_d !== 32'h80) begin $display("FAIL selpc_a got=%h exp=80", exu_lsu_rs1_d); bad++; end
        total++;
        if (exu_lsu_rs2_d !== 32'h55) begin $display("FAIL byp_b got=%h exp=55", exu_lsu_rs2_d); bad++; end
        total++;
        @(posedge clk); #1;
        if (exu_i0_result_e1 !== 32'hD5) begin $display("FAIL selpc_add got=%h exp=d5", exu_i0_result_e1); bad++; end
        total++;
        drain();
    endtask

    task automatic test_branch();
        @(negedge clk);
        drive_br(0, mk_ap(OP_ADD, 0, BR_BEQ, 0, 0), 9, 9, 31'h40, 12'd8, mk_pp(0, 1, 31'h0));
        @(posedge clk); #1;
        if (exu_i0_flush_final !== 1'b1 || exu_flush_final !== 1'b1) begin
            $display("FAIL beq_nt_flush got=%b/%b exp=1/1", exu_i0_flush_final, exu_flush_final); bad++;
        end
        total++;
        if (exu_flush_path_final !== 31'h48) begin $display("FAIL beq_nt_path got=%h exp=48", exu_flush_path_final); bad++; end
        total++;
        drain();
        @(negedge clk);
        drive_br(0, mk_ap(OP_ADD, 0, BR_BEQ, 0, 0), 9, 9, 31'h40, 12'd8, mk_pp(1, 1, 31'h48));
        @(posedge clk); #1;
        if (exu_flush_final !== 1'b0) begin $display("FAIL beq_tk_noflush got=%b exp=0", exu_flush_final); bad++; end
        total++;
        drain();
        @(negedge clk);
        drive_br(0, mk_ap(OP_ADD, 0, BR_BNE, 0, 0), 9, 9, 31'h40, 12'd8, mk_pp(1, 1, 31'h48));
        @(posedge clk); #1;
        if (exu_i0_flush_final !== 1'b1 || exu_flush_path_final !== 31'h42) begin
            $display("FAIL bne_fallthru got=%b/%h exp=1/42", exu_i0_flush_final, exu_flush_path_final); bad++;
        end
        total++;
        drain();
        @(negedge clk);
        drive_br(0, mk_ap(OP_ADD, 0, BR_BLT, 0, 0), 32'hFFFF_FFFF, 1, 31'h40, 12'hFF8, mk_pp(0, 1, 31'h0));
        @(posedge clk); #1;
        if (exu_i0_flush_final !== 1'b1 || exu_flush_path_final !== 31'h38) begin
            $display("FAIL blt_negoff got=%b/%h exp=1/38", exu_i0_flush_final, exu_flush_path_final); bad++;
        end
        total++;
        drain();
        @(negedge clk);
        drive_br(0, mk_ap(OP_ADD, 0, BR_BLT, 1, 0), 32'hFFFF_FFFF, 1, 31'h40, 12'hFF8, mk_pp(0, 1, 31'h0));
        @(posedge clk); #1;
        if (exu_flush_final !== 1'b0) begin $display("FAIL bltu_nt got=%b exp=0", exu_flush_final); bad++; end
        total++;
        drain();
        @(negedge clk);
        drive_br(0, mk_ap(OP_ADD, 1, BR_NONE, 0, 1), 32'h200, 0, 31'h40, 12'd0, mk_pp(0, 0, 31'h0));
        dec_i0_immed_d = 32'h10;
        @(posedge clk); #1;
        if (exu_i0_result_e1 !== 32'h82) begin $display("FAIL jal_link got=%h exp=82", exu_i0_result_e1); bad++; end
        total++;
        if (exu_i0_flush_final !== 1'b1 || exu_flush_path_final !== 31'h108) begin
            $display("FAIL jal_path got=%b/%h exp=1/108", exu_i0_flush_final, exu_flush_path_final); bad++;
        end
        total++;
        drain();
    endtask

    task automatic test_flush_priority();
        @(negedge clk);
        i0_ap = mk_ap(OP_ADD, 0, BR_NONE, 0, 0); dec_i0_alu_decode_d = 1;
        drive_br(1, mk_ap(OP_ADD, 0, BR_BEQ, 0, 0), 4, 4, 31'h78, 12'd8, mk_pp(0, 1, 31'h0));
        @(posedge clk); #1;
        if (exu_i1_flush_final !== 1'b1 || exu_flush_path_final !== 31'h80) begin
            $display("FAIL i1_only got=%b/%h exp=1/80", exu_i1_flush_final, exu_flush_path_final); bad++;
        end
        total++;
        drain();
        @(negedge clk);
        drive_br(0, mk_ap(OP_ADD, 0, BR_BEQ, 0, 0), 9, 9, 31'h40, 12'd8, mk_pp(0, 1, 31'h0));
        drive_br(1, mk_ap(OP_ADD, 0, BR_BEQ, 0, 0), 4, 4, 31'h78, 12'd8, mk_pp(0, 1, 31'h0));
        @(posedge clk); #1;
        if (exu_flush_path_final !== 31'h48) begin $display("FAIL dual_path got=%h exp=48", exu_flush_path_final); bad++; end
        total++;
        if ({exu_i0_flush_final, exu_i1_flush_final} !== 2'b10) begin
            $display("FAIL dual_lanes got=%b%b exp=10", exu_i0_flush_final, exu_i1_flush_final); bad++;
        end
        total++;
        dec_tlu_flush_lower_wb = 1; dec_tlu_flush_path_wb = 31'h1000;
        #1;
        if (exu_flush_path_final !== 31'h1000) begin $display("FAIL tlu_path got=%h exp=1000", exu_flush_path_final); bad++; end
        total++;
        if ({exu_flush_final, exu_i0_flush_final, exu_i1_flush_final} !== 3'b100) begin
            $display("FAIL tlu_lanes got=%b%b%b exp=100", exu_flush_final, exu_i0_flush_final, exu_i1_flush_final); bad++;
        end
        total++;
        drain();
    endtask

    task automatic test_freeze();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            dec_i0_alu_decode_d = 1; i0_ap = mk_ap(OP_ADD, 1, BR_NONE, 0, 0);
            gpr_i0_rs1_d = 32'h10 * (k + 1); dec_i0_immed_d = 0;
            @(posedge clk);
        end
        @(negedge clk);
        gpr_i0_rs1_d = 32'h60; lsu_freeze_dc3 = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (exu_i0_result_e1 !== 32'h50 || exu_i0_result_e4 !== 32'h20) begin
                $display("FAIL freeze_hold%0d got=%h/%h exp=50/20", k, exu_i0_result_e1, exu_i0_result_e4); bad++;
            end
            total++;
        end
        @(negedge clk); lsu_freeze_dc3 = 0;
        @(posedge clk); #1;
        if (exu_i0_result_e1 !== 32'h60 || exu_i0_result_e4 !== 32'h30) begin
            $display("FAIL freeze_resume got=%h/%h exp=60/30", exu_i0_result_e1, exu_i0_result_e4); bad++;
        end
        total++;
        @(negedge clk); idle();
        @(posedge clk); #1;
        if (exu_i0_result_e1 !== 32'h60 || exu_i0_result_e4 !== 32'h40) begin
            $display("FAIL freeze_drain got=%h/%h exp=60/40", exu_i0_result_e1, exu_i0_result_e4); bad++;
        end
        total++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst = 1;
        #1;
        if (exu_i0_result_e1 !== 32'h0 || exu_i0_result_e4 !== 32'h0 || exu_i0_pc_e1 !== 31'h0) begin
            $display("FAIL midrst got=%h/%h/%h exp=0", exu_i0_result_e1, exu_i0_result_e4, exu_i0_pc_e1); bad++;
        end
        total++;
        @(negedge clk); rst = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_add_pipeline();
        test_back_to_back();
        test_bypass();
        test_branch();
        test_flush_priority();
        test_freeze();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
